// File: rtl/cpu_control_unit.sv
// Hard-wired microsequencer for the 16-bit single-bus CPU: fetch, decode, execute.
// Optional: define CU_ILLEGAL_TRAP_EN to trap opcodes 0x5-0x7 into an illegal-halt state.
module cpu_control_unit #(
  parameter logic [2:0] FSEL_PASS = 3'd0,
  parameter logic [2:0] FSEL_ADD  = 3'd1,
  parameter logic [2:0] FSEL_SUB  = 3'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        out,
  output logic [10:0] tArray,
  output logic [8:0]  lArray,
  output logic        readReg,
  output logic        writeReg,
  output logic        readMem,
  output logic        writeMem,
  output logic [3:0]  dsel,
  output logic [2:0]  fsel,
  output logic        halted,
  output logic        illegal,
  output logic        instr_done
);

  typedef enum logic [4:0] {
    S_F0, S_F1, S_F2, S_F3,
    S_E0,
    S_P0, S_P1, S_P2,
    S_Q0, S_Q1, S_Q2, S_Q3,
    S_B0, S_B1, S_B2,
    S_HALT, S_ILL
  } state_t;

  state_t state;

  logic [3:0] opcode;
  logic       op_undef;
  logic       instr_unused;

  assign opcode       = instr[15:12];
  assign op_undef     = (opcode >= 4'h5) && (opcode <= 4'h7);
  assign instr_unused = ^instr[11:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_F0;
    end else begin
      unique case (state)
        S_F0: state <= S_F1;
        S_F1: state <= S_F2;
        S_F2: state <= S_F3;
        S_F3: begin
          if (opcode[3])            state <= S_B0;
          else if (opcode == 4'h1)  state <= S_HALT;
          else if (opcode == 4'h2)  state <= S_P0;
          else if (opcode == 4'h3)  state <= S_Q0;
          else if (opcode == 4'h4)  state <= S_E0;
`ifdef CU_ILLEGAL_TRAP_EN
          else if (op_undef)        state <= S_ILL;
`endif
          else                      state <= S_F0;
        end
        S_E0: state <= S_F0;
        S_P0: state <= S_P1;
        S_P1: state <= S_P2;
        S_P2: state <= S_F0;
        S_Q0: state <= S_Q1;
        S_Q1: state <= S_Q2;
        S_Q2: state <= S_Q3;
        S_Q3: state <= S_F0;
        S_B0: state <= S_B1;
        S_B1: state <= out ? S_B2 : S_F0;
        S_B2: state <= S_F0;
        S_HALT: state <= S_HALT;
        S_ILL:  state <= S_ILL;
        default: state <= S_F0;
      endcase
    end
  end

  // Strobes are forced low while reset is held, even though state already reads F0.
  always_comb begin
    tArray     = '0;
    lArray     = '0;
    readReg    = 1'b0;
    writeReg   = 1'b0;
    readMem    = 1'b0;
    writeMem   = 1'b0;
    dsel       = '0;
    fsel       = FSEL_PASS;
    halted     = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    if (!reset) begin
      unique case (state)
        S_F0: begin tArray[2] = 1'b1; lArray[5] = 1'b1; end
        S_F1: begin readMem = 1'b1; lArray[6] = 1'b1; end
        S_F2: begin tArray[0] = 1'b1; lArray[0] = 1'b1; end
        S_F3: begin
          tArray[2]  = 1'b1;
          fsel       = FSEL_ADD;
          lArray[2]  = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
          instr_done = (opcode == 4'h0);
`else
          instr_done = (opcode == 4'h0) || op_undef;
`endif
        end
        S_E0: begin readReg = 1'b1; writeReg = 1'b1; fsel = FSEL_ADD; instr_done = 1'b1; end
        S_P0: begin tArray[3] = 1'b1; fsel = FSEL_SUB; lArray[3] = 1'b1; lArray[5] = 1'b1; end
        S_P1: begin readReg = 1'b1; lArray[8] = 1'b1; end
        S_P2: begin tArray[4] = 1'b1; writeMem = 1'b1; instr_done = 1'b1; end
        S_Q0: begin tArray[3] = 1'b1; lArray[5] = 1'b1; end
        S_Q1: begin readMem = 1'b1; lArray[7] = 1'b1; end
        S_Q2: begin tArray[5] = 1'b1; writeReg = 1'b1; end
        S_Q3: begin tArray[3] = 1'b1; fsel = FSEL_ADD; lArray[3] = 1'b1; instr_done = 1'b1; end
        S_B0: begin readReg = 1'b1; fsel = FSEL_PASS; end
        // Taken branch stages the offset into T2 in B1 so B2 can add it to PC.
        S_B1: begin
          dsel       = {1'b0, instr[14:12]};
          tArray[7]  = out;
          lArray[0]  = out;
          instr_done = ~out;
        end
        S_B2: begin tArray[2] = 1'b1; fsel = FSEL_ADD; lArray[2] = 1'b1; instr_done = 1'b1; end
        S_HALT: halted = 1'b1;
        S_ILL: begin
          halted = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
          illegal = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: per-cycle strobe vectors for each opcode class.
// Outputs are sampled on the negedge, half a cycle after the state updates.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        out;
  logic [10:0] tArray;
  logic [8:0]  lArray;
  logic        readReg, writeReg, readMem, writeMem;
  logic [3:0]  dsel;
  logic [2:0]  fsel;
  logic        halted, illegal, instr_done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_control_unit #(.FSEL_PASS(3'd0), .FSEL_ADD(3'd1), .FSEL_SUB(3'd2)) dut (
    .clk(clk), .reset(reset), .instr(instr), .out(out),
    .tArray(tArray), .lArray(lArray), .readReg(readReg), .writeReg(writeReg),
    .readMem(readMem), .writeMem(writeMem), .dsel(dsel), .fsel(fsel),
    .halted(halted), .illegal(illegal), .instr_done(instr_done)
  );

  logic [33:0] obs;
  logic        inv_ok;
  assign obs = {tArray, lArray, readReg, writeReg, readMem, writeMem, dsel, fsel,
                halted, illegal, instr_done};
  // At most one bus driver, and register-bank reads never overlap a tri-state drive.
  assign inv_ok = ($countones(tArray) <= 1) && !(readReg && (tArray != '0));

  function automatic logic [33:0] pk(input logic [10:0] t, input logic [8:0] l,
                                     input logic rr, input logic wr, input logic rm,
                                     input logic wm, input logic [3:0] ds, input logic [2:0] fs,
                                     input logic h, input logic il, input logic d);
    return {t, l, rr, wr, rm, wm, ds, fs, h, il, d};
  endfunction

  logic [33:0] V_F0, V_F1, V_F2, V_F3, V_F3D, V_E0, V_P0, V_P1, V_P2;
  logic [33:0] V_Q0, V_Q1, V_Q2, V_Q3, V_B0, V_B1T, V_B1N, V_B2, V_H, V_HI;

  task automatic apply_reset(input logic [15:0] iv, input logic ov);
    reset = 1'b1;
    instr = iv;
    out   = ov;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr = 16'h2080; out = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_hold got %h want %h", obs, 34'h0); end
    reset = 1'b0; #1;
    n_cmp++; if (obs !== V_F0) begin n_bad++; $display("FAIL reset_f0 got %h want %h", obs, V_F0); end
    repeat (4) @(negedge clk);
    n_cmp++; if (obs !== V_P0) begin n_bad++; $display("FAIL pre_abort got %h want %h", obs, V_P0); end
    reset = 1'b1; #1;
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL abort_hold got %h want %h", obs, 34'h0); end
    @(negedge clk); reset = 1'b0; #1;
    n_cmp++; if (obs !== V_F0) begin n_bad++; $display("FAIL abort_f0 got %h want %h", obs, V_F0); end
    @(negedge clk);
    n_cmp++; if (obs !== V_F1) begin n_bad++; $display("FAIL abort_f1 got %h want %h", obs, V_F1); end
  endtask

  task automatic test_nop();
    logic [33:0] e[$];
    e = '{V_F0, V_F1, V_F2, V_F3D, V_F0, V_F1, V_F2, V_F3D, V_F0};
    apply_reset(16'h0000, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL nop c%0d got %h want %h", i, obs, e[i]); end
      n_cmp++; if (!inv_ok) begin n_bad++; $display("FAIL nop_xy c%0d got t=%b rr=%b want exclusive", i, tArray, readReg); end
    end
  endtask

  task automatic test_inc();
    logic [33:0] e[$];
    e = '{V_F0, V_F1, V_F2, V_F3, V_E0, V_F0, V_F1};
    apply_reset(16'h4180, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL inc c%0d got %h want %h", i, obs, e[i]); end
      n_cmp++; if (!inv_ok) begin n_bad++; $display("FAIL inc_xy c%0d got t=%b rr=%b want exclusive", i, tArray, readReg); end
    end
  endtask

  task automatic test_push();
    logic [33:0] e[$];
    e = '{V_F0, V_F1, V_F2, V_F3, V_P0, V_P1, V_P2, V_F0};
    apply_reset(16'h2080, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL push c%0d got %h want %h", i, obs, e[i]); end
      n_cmp++; if (!inv_ok) begin n_bad++; $display("FAIL push_xy c%0d got t=%b rr=%b want exclusive", i, tArray, readReg); end
    end
  endtask

  task automatic test_pop();
    logic [33:0] e[$];
    e = '{V_F0, V_F1, V_F2, V_F3, V_Q0, V_Q1, V_Q2, V_Q3, V_F0};
    apply_reset(16'h3100, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL pop c%0d got %h want %h", i, obs, e[i]); end
      n_cmp++; if (!inv_ok) begin n_bad++; $display("FAIL pop_xy c%0d got t=%b rr=%b want exclusive", i, tArray, readReg); end
    end
  endtask

  task automatic test_branch_taken();
    logic [33:0] e[$];
    e = '{V_F0, V_F1, V_F2, V_F3, V_B0, V_B1T, V_B2, V_F0};
    apply_reset(16'h9004, 1'b1);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL br_taken c%0d got %h want %h", i, obs, e[i]); end
      n_cmp++; if (!inv_ok) begin n_bad++; $display("FAIL br_taken_xy c%0d got t=%b rr=%b want exclusive", i, tArray, readReg); end
    end
  endtask

  task automatic test_branch_not_taken();
    logic [33:0] e[$];
    e = '{V_F0, V_F1, V_F2, V_F3, V_B0, V_B1N, V_F0, V_F1};
    apply_reset(16'hF004, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL br_not c%0d got %h want %h", i, obs, e[i]); end
      n_cmp++; if (!inv_ok) begin n_bad++; $display("FAIL br_not_xy c%0d got t=%b rr=%b want exclusive", i, tArray, readReg); end
    end
  endtask

  task automatic test_halt();
    logic [33:0] e[$];
    e = '{V_F0, V_F1, V_F2, V_F3};
    for (int k = 0; k < 20; k++) e.push_back(V_H);
    apply_reset(16'h1000, 1'b0);
    for (int i = 0; i < e.size(); i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL halt c%0d got %h want %h", i, obs, e[i]); end
    end
    apply_reset(16'h0000, 1'b0);
    n_cmp++; if (obs !== V_F0) begin n_bad++; $display("FAIL halt_clear got %h want %h", obs, V_F0); end
  endtask

  task automatic test_illegal();
    logic [15:0] ops[3];
    logic [33:0] e[$];
    ops = '{16'h5000, 16'h6000, 16'h7000};
`ifdef CU_ILLEGAL_TRAP_EN
    e = '{V_F0, V_F1, V_F2, V_F3};
    for (int k = 0; k < 20; k++) e.push_back(V_HI);
`else
    e = '{V_F0, V_F1, V_F2, V_F3D, V_F0, V_F1};
`endif
    for (int j = 0; j < 3; j++) begin
      apply_reset(ops[j], 1'b0);
      for (int i = 0; i < e.size(); i++) begin
        if (i > 0) @(negedge clk);
        n_cmp++; if (obs !== e[i]) begin n_bad++; $display("FAIL illegal_%h c%0d got %h want %h", ops[j], i, obs, e[i]); end
      end
      reset = 1'b1; #1;
      n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL illegal_rst_%h got %h want %h", ops[j], obs, 34'h0); end
      @(negedge clk); reset = 1'b0; #1;
      n_cmp++; if (obs !== V_F0) begin n_bad++; $display("FAIL illegal_f0_%h got %h want %h", ops[j], obs, V_F0); end
    end
  endtask

  initial begin
    reset = 1'b1; instr = '0; out = 1'b0;
    //          t        l        rr wr rm wm dsel fsel h il d
    V_F0  = pk(11'h004, 9'h020, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0);
    V_F1  = pk(11'h000, 9'h040, 0, 0, 1, 0, 4'd0, 3'd0, 0, 0, 0);
    V_F2  = pk(11'h001, 9'h001, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0);
    V_F3  = pk(11'h004, 9'h004, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0, 0);
    V_F3D = pk(11'h004, 9'h004, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0, 1);
    V_E0  = pk(11'h000, 9'h000, 1, 1, 0, 0, 4'd0, 3'd1, 0, 0, 1);
    V_P0  = pk(11'h008, 9'h028, 0, 0, 0, 0, 4'd0, 3'd2, 0, 0, 0);
    V_P1  = pk(11'h000, 9'h100, 1, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0);
    V_P2  = pk(11'h010, 9'h000, 0, 0, 0, 1, 4'd0, 3'd0, 0, 0, 1);
    V_Q0  = pk(11'h008, 9'h020, 0, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0);
    V_Q1  = pk(11'h000, 9'h080, 0, 0, 1, 0, 4'd0, 3'd0, 0, 0, 0);
    V_Q2  = pk(11'h020, 9'h000, 0, 1, 0, 0, 4'd0, 3'd0, 0, 0, 0);
    V_Q3  = pk(11'h008, 9'h008, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0, 1);
    V_B0  = pk(11'h000, 9'h000, 1, 0, 0, 0, 4'd0, 3'd0, 0, 0, 0);
    V_B1T = pk(11'h080, 9'h001, 0, 0, 0, 0, 4'd1, 3'd0, 0, 0, 0);
    V_B1N = pk(11'h000, 9'h000, 0, 0, 0, 0, 4'd7, 3'd0, 0, 0, 1);
    V_B2  = pk(11'h004, 9'h004, 0, 0, 0, 0, 4'd0, 3'd1, 0, 0, 1);
    V_H   = pk(11'h000, 9'h000, 0, 0, 0, 0, 4'd0, 3'd0, 1, 0, 0);
    V_HI  = pk(11'h000, 9'h000, 0, 0, 0, 0, 4'd0, 3'd0, 1, 1, 0);

    test_reset();
    test_nop();
    test_inc();
    test_push();
    test_pop();
    test_branch_taken();
    test_branch_not_taken();
    test_halt();
    test_illegal();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
